// File: rtl/cpu_pkg.sv
// Shared types and defaults for the 8-bit single-cycle CPU.
// Memory FSM states and sizing helpers live here.
package cpu_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LATENCY    = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    // Wide enough to hold LATENCY itself after the final increment.
    function automatic int cnt_width(input int lat);
        return $clog2(lat) + 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Data memory storage: synchronous write and read, cleared on reset.
// One enable pulse performs either a store or a load.
module dmem_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Clear every word on reset; otherwise store or load on the enable pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_memory.sv
// Slow word-addressed data memory with BUSYWAIT stall handshake.
// A request is latched in IDLE, performed after LATENCY cycles, then DONE.
module data_memory
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [DATA_WIDTH-1:0] WRITEDATA,
    output logic [DATA_WIDTH-1:0] READDATA,
    output logic                  BUSYWAIT
);

    localparam int CW = cnt_width(LATENCY);
    localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

    state_t                state;
    state_t                next_state;
    logic [CW-1:0]         counter;
    logic                  op_we;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  req;
    logic                  fire;

    assign req = READ | WRITE;

    // State register and access-cycle counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            state <= next_state;
            if (state == ACCESS) begin
                counter <= counter + 1'b1;
            end else begin
                counter <= '0;
            end
        end
    end

    // Capture the request in IDLE; a simultaneous READ+WRITE becomes a store.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            op_we  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (state == IDLE && req) begin
            op_we  <= WRITE;
            addr_q <= ADDRESS;
            data_q <= WRITEDATA;
        end
    end

    // Next-state, stall output and the single access pulse.
    always_comb begin
        next_state = state;
        BUSYWAIT   = 1'b0;
        fire       = 1'b0;
        unique case (state)
            IDLE: begin
                BUSYWAIT = req;
                if (req) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                BUSYWAIT = 1'b1;
                if (counter == LAST) begin
                    fire       = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_array (
        .CLK  (CLK),
        .RESET(RESET),
        .en   (fire),
        .we   (op_we),
        .addr (addr_q),
        .wdata(data_q),
        .rdata(READDATA)
    );

endmodule
